i2s_tx: RTL and testbench



---
 rtl/i2s_tx.sv | 188 ++++++++++++++++++
 tb/tb_i2s_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter: SCK/WS generation, MSB-first serialisation on SDO,
// with a first-word fall-through sample FIFO written by the bus wrapper.
module i2s_tx #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    sck_prescaler,
    input  logic [5:0]    sample_size,
    input  logic          left_justified,
    input  logic [1:0]    channels,
    input  logic          fifo_wr,
    input  logic [DW-1:0] fifo_wdata,
    input  logic          fifo_clr,
    input  logic [AW-1:0] fifo_level_threshold,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    output logic          overflow,
    output logic          sck,
    output logic          ws,
    output logic          sdo
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [AW:0] DepthLvl = (AW + 1)'(Depth);

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push;
    logic          pop;
    logic          overflow_q;

    assign fifo_full        = (level_q == DepthLvl);
    assign fifo_empty       = (level_q == '0);
    assign fifo_level       = level_q;
    assign fifo_level_below = (level_q < {1'b0, fifo_level_threshold});
    assign push             = fifo_wr & ~fifo_full;
    assign overflow         = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fifo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= fifo_wr & fifo_full;
        end
    end

    // ------------------------------------------------------------------
    // Serial generator
    // ------------------------------------------------------------------
    logic [7:0]  presc_q, presc_d;
    logic        sck_q, sck_d;
    logic        ws_q, ws_d;
    logic        sdo_q, sdo_d;
    logic        lj_q, lj_d;
    logic [4:0]  bit_ctr_q, bit_ctr_d;
    logic [31:0] shift_q, shift_d;
    logic        delay_d;
    logic        underflow_q, underflow_d;
    logic        fe;
    logic        boundary;
    logic        slot_en;
    logic [5:0]  eff_size;
    logic [5:0]  shamt;
    logic [31:0] head_ext;
    logic [31:0] load_val;

    if (DW >= 32) begin : g_head_trunc
        assign head_ext = mem_q[rd_ptr_q][31:0];
    end else begin : g_head_zext
        assign head_ext = {{(32 - DW){1'b0}}, mem_q[rd_ptr_q]};
    end

    assign fe       = en & (presc_q == '0) & sck_q;
    assign boundary = fe & (bit_ctr_q == 5'd31);
    // The slot being entered has ws = ~ws_q: old ws=1 means the left slot starts.
    assign slot_en  = ws_q ? channels[1] : channels[0];
    assign pop      = boundary & slot_en & ~fifo_empty;

    assign eff_size = ((sample_size == 6'd0) || (sample_size > 6'd32)) ? 6'd32 : sample_size;
    assign shamt    = 6'd32 - eff_size;
    assign load_val = head_ext << shamt;

    always_comb begin
        presc_d     = presc_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        sdo_d       = sdo_q;
        lj_d        = lj_q;
        bit_ctr_d   = bit_ctr_q;
        shift_d     = shift_q;
        delay_d     = 1'b0;
        underflow_d = boundary & slot_en & fifo_empty;

        if (en) begin
            if (presc_q == '0) begin
                presc_d = sck_prescaler;
                sck_d   = ~sck_q;
            end else begin
                presc_d = presc_q - 8'd1;
            end
        end

        if (fe) begin
            bit_ctr_d = bit_ctr_q + 5'd1;
            delay_d   = shift_q[31];
            if (boundary) begin
                ws_d    = ~ws_q;
                lj_d    = left_justified;
                shift_d = pop ? load_val : 32'd0;
            end else begin
                shift_d = {shift_q[30:0], 1'b0};
            end
            // In I2S mode the sdo register itself is the one-SCK delay stage.
            sdo_d = lj_d ? shift_d[31] : delay_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc_q   <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b1;
            sdo_q     <= 1'b0;
            lj_q      <= 1'b0;
            bit_ctr_q <= 5'd31;
            shift_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            sdo_q     <= sdo_d;
            lj_q      <= lj_d;
            bit_ctr_q <= bit_ctr_d;
            shift_q   <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign sck       = sck_q;
    assign ws        = ws_q;
    assign sdo       = sdo_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx: framing, data alignment, slot
// selection, underflow/overflow and FIFO status.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  sck_prescaler;
    logic [5:0]  sample_size;
    logic        left_justified;
    logic [1:0]  channels;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        fifo_clr;
    logic [3:0]  fifo_level_threshold;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        fifo_level_below;
    logic        underflow;
    logic        overflow;
    logic        sck;
    logic        ws;
    logic        sdo;

    int checks = 0;
    int errors = 0;

    i2s_tx #(
        .DW(32),
        .AW(4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .en                   (en),
        .sck_prescaler        (sck_prescaler),
        .sample_size          (sample_size),
        .left_justified       (left_justified),
        .channels             (channels),
        .fifo_wr              (fifo_wr),
        .fifo_wdata           (fifo_wdata),
        .fifo_clr             (fifo_clr),
        .fifo_level_threshold (fifo_level_threshold),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_level           (fifo_level),
        .fifo_level_below     (fifo_level_below),
        .underflow            (underflow),
        .overflow             (overflow),
        .sck                  (sck),
        .ws                   (ws),
        .sdo                  (sdo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the clk right after the next SCK falling edge.
    task automatic next_fe(output int nc);
        logic p;
        nc = 0;
        p  = sck;
        forever begin
            step();
            nc++;
            if (p && !sck) break;
            p = sck;
            if (nc >= 600) begin
                checks++;
                errors++;
                $error("FAIL fe_timeout observed=%0d expected=<600", nc);
                break;
            end
        end
    endtask

    task automatic collect(input int n, output logic [31:0] w, output int nc);
        w  = '0;
        nc = 0;
        for (int i = 0; i < n; i++) begin
            next_fe(nc);
            w = {w[30:0], sdo};
        end
    endtask

    task automatic push(input logic [31:0] d);
        fifo_wr    = 1'b1;
        fifo_wdata = d;
        step();
        fifo_wr    = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic        b0;
        int          nc;
        int          ucount;
        int          ones;

        rst                  = 1'b1;
        en                   = 1'b0;
        sck_prescaler        = 8'd1;
        sample_size          = 6'd32;
        left_justified       = 1'b0;
        channels             = 2'b11;
        fifo_wr              = 1'b0;
        fifo_wdata           = '0;
        fifo_clr             = 1'b0;
        fifo_level_threshold = 4'd4;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_sck", sck, 0);
        chk("rst_ws", ws, 1);
        chk("rst_sdo", sdo, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_below", fifo_level_below, 1);

        // I2S stereo, 32-bit
        push(32'hA5A5A5A5);
        push(32'h5A5A5A5A);
        chk("i2s_level2", fifo_level, 2);
        en = 1'b1;
        next_fe(nc);
        chk("i2s_first_fe_lat", nc, 3);
        chk("i2s_ws_left", ws, 0);
        chk("i2s_sdo_fe0", sdo, 0);
        chk("i2s_level1", fifo_level, 1);
        collect(32, w, nc);
        chk("i2s_left_word", w, 32'hA5A5A5A5);
        chk("i2s_sck_period", nc, 4);
        chk("i2s_ws_right", ws, 1);
        chk("i2s_empty", fifo_empty, 1);
        collect(32, w, nc);
        chk("i2s_right_word", w, 32'h5A5A5A5A);
        chk("i2s_ws_left2", ws, 0);
        chk("i2s_underflow", underflow, 1);
        step();
        chk("i2s_underflow_pulse", underflow, 0);
        en = 1'b0;
        step();
        chk("dis_sck", sck, 0);
        chk("dis_ws", ws, 1);

        // Left-justified stereo
        push(32'hA5A5A5A5);
        push(32'h5A5A5A5A);
        left_justified = 1'b1;
        en = 1'b1;
        next_fe(nc);
        chk("lj_ws_left", ws, 0);
        chk("lj_msb_at_ws_edge", sdo, 1);
        b0 = sdo;
        collect(31, w, nc);
        chk("lj_left_word", {b0, w[30:0]}, 32'hA5A5A5A5);
        next_fe(nc);
        chk("lj_ws_right", ws, 1);
        b0 = sdo;
        collect(31, w, nc);
        chk("lj_right_word", {b0, w[30:0]}, 32'h5A5A5A5A);
        en = 1'b0;
        left_justified = 1'b0;
        step();

        // 16-bit samples, left only
        sample_size = 6'd16;
        channels    = 2'b10;
        push(32'h0000BEEF);
        push(32'h00001234);
        en = 1'b1;
        next_fe(nc);
        chk("s16_level_after_left", fifo_level, 1);
        collect(32, w, nc);
        chk("s16_left_word", w, 32'hBEEF0000);
        chk("s16_ws_right", ws, 1);
        chk("s16_no_pop_right", fifo_level, 1);
        chk("s16_no_underflow_right", underflow, 0);
        collect(32, w, nc);
        chk("s16_right_zero", w, 32'h0);
        chk("s16_ws_left2", ws, 0);
        chk("s16_level_after_left2", fifo_level, 0);
        en = 1'b0;
        step();

        // Underflow with empty FIFO, then a late push
        sample_size = 6'd32;
        channels    = 2'b11;
        fifo_clr    = 1'b1;
        step();
        fifo_clr    = 1'b0;
        chk("clr_empty", fifo_empty, 1);
        en     = 1'b1;
        ucount = 0;
        ones   = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            ucount += int'(underflow);
            ones   += int'(sdo);
        end
        chk("uf_pulses_per_frame", ucount, 2);
        chk("uf_sdo_zero", ones, 0);
        push(32'h96C3F00F);
        next_fe(nc);
        chk("uf_ws_left", ws, 0);
        chk("uf_no_pulse_loaded", underflow, 0);
        chk("uf_popped", fifo_level, 0);
        collect(32, w, nc);
        chk("uf_late_word", w, 32'h96C3F00F);
        chk("uf_right_pulse", underflow, 1);
        en = 1'b0;
        step();

        // FIFO fill, threshold and overflow
        for (int i = 0; i < 3; i++) push(32'h10000000 + 32'(i));
        chk("lvl3", fifo_level, 3);
        chk("below_at_3", fifo_level_below, 1);
        push(32'h10000003);
        chk("lvl4", fifo_level, 4);
        chk("below_at_4", fifo_level_below, 0);
        for (int i = 4; i < 16; i++) push(32'h10000000 + 32'(i));
        chk("full16", fifo_full, 1);
        chk("lvl16", fifo_level, 16);
        chk("no_overflow_16", overflow, 0);
        push(32'hDEADBEEF);
        chk("overflow_17", overflow, 1);
        chk("lvl16_after_drop", fifo_level, 16);
        step();
        chk("overflow_pulse", overflow, 0);

        // Ordering from a full FIFO, then reset mid-slot
        en = 1'b1;
        next_fe(nc);
        chk("full_pop_level", fifo_level, 15);
        collect(32, w, nc);
        chk("fifo_order_word0", w, 32'h10000000);
        chk("full_pop_level2", fifo_level, 14);
        collect(5, w, nc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sck", sck, 0);
        chk("midrst_ws", ws, 1);
        chk("midrst_sdo", sdo, 0);
        chk("midrst_empty", fifo_empty, 1);
        chk("midrst_level", fifo_level, 0);
        next_fe(nc);
        chk("midrst_first_fe_lat", nc, 3);
        chk("midrst_ws_left", ws, 0);
        chk("midrst_underflow", underflow, 1);
        en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
